trace_stack: RTL and testbench
==============================

Name: trace_stack

Overview:
- LIFO trail of variable assignments for the SAT solver; responder to the control FSM's push/pop trace interface.
- Control pushes each decision or implied assignment and pops entries during backtracking.
- Top-of-stack fields are presented registered so control can inspect var/val/type before issuing a pop.
- Sits between control and var-state; owns no solver policy.

Parameters:
- VAR_BITS, `MAX_VARS_BITS, width of the variable index.
- DEPTH, 256, maximum number of stacked entries.
- PTR_BITS, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low; stack cleared while 0.
- clear_trace  input  1  synchronous flush at the start of a new solve.
- push_trace  input  1  push {var,val,type} this cycle.
- pop_trace  input  1  pop the top entry this cycle.
- var_in_trace  input  VAR_BITS  variable index to push.
- val_in_trace  input  1  assigned value to push.
- type_in_trace  input  1  1 = decision, 0 = implied.
- var_out_trace  output  VAR_BITS  top entry variable index.
- val_out_trace  output  1  top entry value.
- type_out_trace  output  1  top entry type.
- empty_trace  output  1  occupancy == 0.
- full_trace  output  1  occupancy == DEPTH.
- count_trace  output  PTR_BITS  current occupancy.
- overflow_err  output  1  sticky: push dropped because the stack was full.
- underflow_err  output  1  sticky: pop requested while empty.

Behaviour:
- Reset (async, active-low):
  - count = 0, empty_trace = 1, full_trace = 0.
  - var/val/type outputs = 0; both error flags = 0.
  - Memory contents are don't-care.
- Outputs are registered; all updates take effect on the clock edge that samples the command. Top-of-stack latency is 1 cycle after push or pop.
- When empty, var/val/type outputs are driven to 0.
- Command priority per cycle: clear_trace > push/pop.
  - clear: count = 0, outputs = 0, error flags unchanged. Pending push/pop is ignored.
- Push only, not full:
  - mem[count] = in; count + 1.
  - Top outputs = in fields.
- Push only, full:
  - Nothing stored; count unchanged.
  - overflow_err set to 1.
- Pop only, count > 1:
  - count - 1.
  - Top outputs = mem[count-2] (the new top, read from the stored array).
- Pop only, count == 1:
  - count = 0, outputs = 0.
- Pop only, empty:
  - No state change; underflow_err set to 1.
- Push and pop together, not empty (including full):
  - Top entry replaced: mem[count-1] = in; count unchanged.
  - Top outputs = in fields. No error flagged.
- Push and pop together, empty:
  - Treated as push.
  - underflow_err set to 1.
- Error flags are sticky until reset deasserts and reasserts, or until reset is held low. clear_trace does not clear them.
- Reset asserted mid-operation: immediate return to the reset state regardless of the clock.
- The index arithmetic never wraps: count is saturated by the full and empty guards.

Optional Feature:
- Macro: TRACE_DECISION_LEVEL_EN.
- When defined:
  - Adds output decision_level (PTR_BITS) = number of type = 1 entries currently on the stack. Reset value 0.
  - Push of a decision: +1.
  - Pop of a decision: -1.
  - Replace adjusts by (new type - old type).
  - clear sets it to 0.
  - Dropped or ignored commands leave it unchanged.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Hold reset = 0 for 2 cycles, then release → count 0, empty_trace 1, outputs 0, both error flags 0.
- Push (5,1,1), then (9,0,0), then (3,1,0) → top (3,1,0), count 3. Pop twice → top (5,1,1) after the second pop, count 1, empty_trace 0.
- Fill with DEPTH pushes (var = i) → full_trace 1. Push once more → overflow_err 1, count DEPTH, top var = DEPTH-1. Then push+pop with (7,1,1) → top (7,1,1), count DEPTH.
- Pop on empty stack → underflow_err 1, count 0. Push+pop (4,0,1) on empty → count 1, top (4,0,1).
- Push 3 entries, then assert clear_trace together with push → count 0, empty_trace 1, pushed data discarded. Error flags keep their prior values.
- With TRACE_DECISION_LEVEL_EN: push types 1,0,1,0 → decision_level 2. Pop twice → 1. Replace the top (type 0) with type 1 → 2.

Source files
------------

// File: rtl/trace_stack.sv
// LIFO trail of solver assignments {var,val,type} with a registered top-of-stack view.
// Optional TRACE_DECISION_LEVEL_EN adds a live count of decision entries on the stack.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module trace_stack #(
    parameter int VAR_BITS = `MAX_VARS_BITS,
    parameter int DEPTH    = 256,
    parameter int PTR_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_trace,
    input  logic                push_trace,
    input  logic                pop_trace,
    input  logic [VAR_BITS-1:0] var_in_trace,
    input  logic                val_in_trace,
    input  logic                type_in_trace,
    output logic [VAR_BITS-1:0] var_out_trace,
    output logic                val_out_trace,
    output logic                type_out_trace,
    output logic                empty_trace,
    output logic                full_trace,
    output logic [PTR_BITS-1:0] count_trace,
    output logic                overflow_err,
    output logic                underflow_err
`ifdef TRACE_DECISION_LEVEL_EN
    ,
    output logic [PTR_BITS-1:0] decision_level
`endif
);

    localparam int ADDR_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_BITS = VAR_BITS + 2;
    localparam logic [PTR_BITS-1:0] DEPTH_P = PTR_BITS'(DEPTH);

    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [ENTRY_BITS-1:0] top;
    logic [ENTRY_BITS-1:0] entry_in;
    logic [PTR_BITS-1:0]   count;
    logic [PTR_BITS-1:0]   below_top;
    logic [PTR_BITS-1:0]   wr_addr;
    logic is_empty, is_full;
    logic cmd_push, cmd_repl, cmd_pop, cmd_ovf, cmd_unf;

    assign entry_in  = {var_in_trace, val_in_trace, type_in_trace};
    assign is_empty  = (count == '0);
    assign is_full   = (count == DEPTH_P);
    assign below_top = count - PTR_BITS'(2);

    // Push+pop on an empty stack degenerates to a plain push (plus underflow).
    assign cmd_push = !clear_trace && push_trace && (!pop_trace || is_empty) && !is_full;
    assign cmd_repl = !clear_trace && push_trace && pop_trace && !is_empty;
    assign cmd_pop  = !clear_trace && pop_trace && !push_trace && !is_empty;
    assign cmd_ovf  = !clear_trace && push_trace && !pop_trace && is_full;
    assign cmd_unf  = !clear_trace && pop_trace && is_empty;

    assign wr_addr = cmd_repl ? (count - PTR_BITS'(1)) : count;

    always_ff @(posedge clock) begin
        if (cmd_push || cmd_repl)
            mem[wr_addr[ADDR_BITS-1:0]] <= entry_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count         <= '0;
            top           <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (cmd_ovf) overflow_err  <= 1'b1;
            if (cmd_unf) underflow_err <= 1'b1;
            if (clear_trace) begin
                count <= '0;
                top   <= '0;
            end else if (cmd_push) begin
                count <= count + PTR_BITS'(1);
                top   <= entry_in;
            end else if (cmd_repl) begin
                top   <= entry_in;
            end else if (cmd_pop) begin
                count <= count - PTR_BITS'(1);
                top   <= (count == PTR_BITS'(1)) ? '0 : mem[below_top[ADDR_BITS-1:0]];
            end
        end
    end

`ifdef TRACE_DECISION_LEVEL_EN
    // Old type for replace/pop comes from the registered top, which mirrors mem[count-1].
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            decision_level <= '0;
        end else if (clear_trace) begin
            decision_level <= '0;
        end else if (cmd_push) begin
            if (type_in_trace) decision_level <= decision_level + PTR_BITS'(1);
        end else if (cmd_repl) begin
            if (type_in_trace && !top[0])      decision_level <= decision_level + PTR_BITS'(1);
            else if (!type_in_trace && top[0]) decision_level <= decision_level - PTR_BITS'(1);
        end else if (cmd_pop) begin
            if (top[0]) decision_level <= decision_level - PTR_BITS'(1);
        end
    end
`endif

    assign var_out_trace  = top[ENTRY_BITS-1:2];
    assign val_out_trace  = top[1];
    assign type_out_trace = top[0];
    assign empty_trace    = is_empty;
    assign full_trace     = is_full;
    assign count_trace    = count;

endmodule

// File: tb/tb_trace_stack.sv
// Randomized bench for trace_stack against a queue-based model of the trail.
module tb_trace_stack;

    localparam int VB = 8;
    localparam int DEPTH = 16;
    localparam int PB = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [VB-1:0] v;
        logic          val;
        logic          typ;
    } entry_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clear_trace = 1'b0, push_trace = 1'b0, pop_trace = 1'b0;
    logic [VB-1:0] var_in_trace = '0;
    logic val_in_trace = 1'b0, type_in_trace = 1'b0;
    logic [VB-1:0] var_out_trace;
    logic val_out_trace, type_out_trace, empty_trace, full_trace;
    logic [PB-1:0] count_trace;
    logic overflow_err, underflow_err;
`ifdef TRACE_DECISION_LEVEL_EN
    logic [PB-1:0] decision_level;
`endif

    trace_stack #(.VAR_BITS(VB), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .clear_trace(clear_trace),
        .push_trace(push_trace), .pop_trace(pop_trace),
        .var_in_trace(var_in_trace), .val_in_trace(val_in_trace),
        .type_in_trace(type_in_trace), .var_out_trace(var_out_trace),
        .val_out_trace(val_out_trace), .type_out_trace(type_out_trace),
        .empty_trace(empty_trace), .full_trace(full_trace),
        .count_trace(count_trace), .overflow_err(overflow_err),
        .underflow_err(underflow_err)
`ifdef TRACE_DECISION_LEVEL_EN
        , .decision_level(decision_level)
`endif
    );

    always #5 clock = ~clock;

    entry_t q[$];
    bit m_ovf, m_unf;
    bit chk_en = 1'b0;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic entry_t m_top();
        entry_t e;
        e = '0;
        if (q.size() > 0) e = q[q.size()-1];
        return e;
    endfunction

    function automatic int m_dlev();
        int n = 0;
        foreach (q[i]) if (q[i].typ) n++;
        return n;
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void m_apply(input bit c, input bit p, input bit o, input entry_t e);
        if (c) q.delete();
        else if (p && o) begin
            if (q.size() == 0) begin q.push_back(e); m_unf = 1'b1; end
            else q[q.size()-1] = e;
        end else if (p) begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else q.push_back(e);
        end else if (o) begin
            if (q.size() == 0) m_unf = 1'b1;
            else void'(q.pop_back());
        end
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            entry_t t;
            t = m_top();
            chk("count", int'(count_trace), q.size());
            chk("empty", int'(empty_trace), int'(q.size() == 0));
            chk("full", int'(full_trace), int'(q.size() == DEPTH));
            chk("top_var", int'(var_out_trace), int'(t.v));
            chk("top_val", int'(val_out_trace), int'(t.val));
            chk("top_type", int'(type_out_trace), int'(t.typ));
            chk("overflow", int'(overflow_err), int'(m_ovf));
            chk("underflow", int'(underflow_err), int'(m_unf));
`ifdef TRACE_DECISION_LEVEL_EN
            chk("dlevel", int'(decision_level), m_dlev());
`endif
        end
    end

    task automatic step(input bit c, input bit p, input bit o,
                        input int v, input bit vl, input bit tp);
        entry_t e;
        e.v = VB'(v); e.val = vl; e.typ = tp;
        @(negedge clock);
        #1;
        clear_trace = c; push_trace = p; pop_trace = o;
        var_in_trace = e.v; val_in_trace = vl; type_in_trace = tp;
        @(posedge clock);
        m_apply(c, p, o, e);
        #1;
        clear_trace = 1'b0; push_trace = 1'b0; pop_trace = 1'b0;
    endtask

    task automatic top_is(input string name, input int v, input int vl, input int tp, input int cnt);
        chk({name, "_var"}, int'(var_out_trace), v);
        chk({name, "_val"}, int'(val_out_trace), vl);
        chk({name, "_type"}, int'(type_out_trace), tp);
        chk({name, "_count"}, int'(count_trace), cnt);
    endtask

    initial begin
        m_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        top_is("reset", 0, 0, 0, 0);
        chk("reset_empty", int'(empty_trace), 1);
        chk("reset_full", int'(full_trace), 0);
        chk("reset_ovf", int'(overflow_err), 0);
        chk("reset_unf", int'(underflow_err), 0);
        reset = 1'b1;
        chk_en = 1'b1;

        step(0, 1, 0, 5, 1, 1);
        step(0, 1, 0, 9, 0, 0);
        step(0, 1, 0, 3, 1, 0);
        top_is("push3", 3, 1, 0, 3);
        step(0, 0, 1, 0, 0, 0);
        top_is("pop1", 9, 0, 0, 2);
        step(0, 0, 1, 0, 0, 0);
        top_is("pop2", 5, 1, 1, 1);
        chk("pop2_empty", int'(empty_trace), 0);

        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, i, i[0], i[1]);
        chk("fill_full", int'(full_trace), 1);
        step(0, 1, 0, 99, 1, 1);
        chk("ovf_set", int'(overflow_err), 1);
        top_is("ovf", DEPTH-1, (DEPTH-1) & 1, ((DEPTH-1) >> 1) & 1, DEPTH);
        step(0, 1, 1, 7, 1, 1);
        top_is("repl_full", 7, 1, 1, DEPTH);
        chk("repl_full_unf", int'(underflow_err), 0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("unf_set", int'(underflow_err), 1);
        chk("unf_count", int'(count_trace), 0);
        step(0, 1, 1, 4, 0, 1);
        top_is("pp_empty", 4, 0, 1, 1);

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 11, 1, 0);
        step(0, 1, 0, 12, 0, 1);
        step(0, 1, 0, 13, 1, 1);
        step(1, 1, 0, 14, 1, 1);
        top_is("clear", 0, 0, 0, 0);
        chk("clear_empty", int'(empty_trace), 1);
        chk("clear_ovf", int'(overflow_err), 1);
        chk("clear_unf", int'(underflow_err), 1);

`ifdef TRACE_DECISION_LEVEL_EN
        step(0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 2, 0, 0);
        step(0, 1, 0, 3, 0, 1);
        step(0, 1, 0, 4, 0, 0);
        chk("dl_push", int'(decision_level), 2);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("dl_pop", int'(decision_level), 1);
        step(0, 1, 1, 8, 1, 1);
        chk("dl_repl", int'(decision_level), 2);
        step(1, 0, 0, 0, 0, 0);
        chk("dl_clear", int'(decision_level), 0);
`endif

        // Async reset away from any clock edge clears the sticky flags.
        @(posedge clock);
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        chk("async_ovf", int'(overflow_err), 0);
        chk("async_unf", int'(underflow_err), 0);
        chk("async_count", int'(count_trace), 0);
        @(negedge clock);
        #1;
        reset = 1'b1;

        for (int ph = 0; ph < 4; ph++) begin
            int wpush;
            wpush = (ph == 0) ? 70 : (ph == 1) ? 30 : (ph == 2) ? 50 : 90;
            for (int n = 0; n < 500; n++) begin
                int r;
                bit p, o, c;
                r = $urandom_range(99);
                c = ($urandom_range(99) < 2);
                p = (r < wpush);
                o = ($urandom_range(99) < ((ph == 3) ? 40 : 100 - wpush));
                step(c, p, o, $urandom_range(255), 1'($urandom), 1'($urandom));
            end
        end

        @(negedge clock);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
